pipe_fetch: RTL and testbench
=============================

Name: pipe_fetch

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. It consumes the redirect and stall signals produced by the decode stage (bpc, jpc, jump-register target, pcsource, wpcir). It drives the instruction-memory request and presents dpc4/inst to decode. The architecture uses delayed branches, so the delay-slot instruction is always fetched and never flushed. A handshake with a possibly multi-cycle instruction memory inserts bubbles, and a pending-redirect latch keeps branch targets from being lost while fetch waits.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP, 32'h0000_0000, instruction word injected as a bubble (sll $0,$0,0).

Ports:
clock  in  1  pipeline clock; all registers update on the rising edge.
resetn  in  1  asynchronous, active-low reset.
bpc  in  32  branch target from decode.
jpc  in  32  jump target from decode.
rpc  in  32  jump-register target (forwarded rs value) from decode.
pcsource  in  2  next-PC select: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
wpcir  in  1  1 = PC and IF/ID may advance; 0 = load-use stall.
imem_rdy  in  1  instruction memory has imem_rdata valid this cycle.
imem_rdata  in  32  fetched instruction word.
imem_addr  out  32  fetch address; equals pc.
imem_req  out  1  fetch request.
pc  out  32  current fetch PC.
dpc4  out  32  IF/ID: PC+4 of the instruction in decode.
inst  out  32  IF/ID: instruction in decode.
dvalid  out  1  IF/ID: 1 = inst is real, 0 = bubble.

Behaviour:
Reset (resetn=0, asynchronous):
- pc=RESET_PC; dpc4=0; inst=NOP; dvalid=0; pend_valid=0; pend_pc=0.
- imem_req=0 while resetn=0; 1 in every cycle after reset.
- A reset mid-wait discards any pending redirect.

Combinational:
- pc4 = pc+4, modulo 2^32; wraps from FFFF_FFFC to 0.
- tgt selects by pcsource: 00 pc4, 01 bpc, 10 rpc, 11 jpc.
- npc = pend_pc if pend_valid, else tgt.
- adv = wpcir & imem_rdy.

Rising edge, in priority order:
- wpcir=0: pc, dpc4, inst, dvalid and the pending state all hold. imem_rdy is ignored and the fetch is re-issued.
- wpcir=1, imem_rdy=1 (adv):
  - pc<=npc; dpc4<=pc4; inst<=imem_rdata; dvalid<=1.
  - pend_valid<=0.
- wpcir=1, imem_rdy=0:
  - pc holds; inst<=NOP; dvalid<=0; dpc4 holds.
  - If pend_valid=0 and pcsource!=00: pend_pc<=tgt, pend_valid<=1. This captures the redirect of the branch leaving decode; the delay slot at pc is still to be fetched.
  - If pend_valid=1: the pending state holds, and pcsource is ignored because decode now holds a bubble.

Latency and throughput:
- With imem_rdy tied high and no stalls, one instruction per cycle.
- inst appears in decode one edge after its address is on imem_addr.

Delayed branch:
- A taken redirect applies to the fetch after the delay slot.
- The delay slot always enters decode with dvalid=1.

Decomposition:
- Shared package pipe_pkg holds the PCSRC_SEQ/BR/JR/J encodings (2'b00/01/10/11), the NOP constant and RESET_PC.
- Optional sub-module pipe_npc_mux: a combinational 4:1 32-bit next-PC select plus the pending override.
- The register logic stays in pipe_fetch.

Test Plan:
- Reset, then imem_rdy=1, wpcir=1, pcsource=00 for 4 cycles -> pc goes 0,4,8,C,10; dpc4 goes 4,8,C,10; inst follows imem_rdata; dvalid=1 from the first edge.
- Branch in decode with pcsource=01, bpc=0x40, pc=0x10, rdy=1 -> next edge pc=0x40, inst=word@0x10 (delay slot), dpc4=0x14.
- Same branch but imem_rdy=0 for 2 cycles -> inst=NOP, dvalid=0, pend_pc=0x40 latched. On the edge with rdy=1: inst=word@0x10, pc=0x40, pend_valid=0.
- wpcir=0 for 3 cycles with imem_rdy toggling -> pc, dpc4, inst and dvalid are unchanged. When wpcir returns to 1 -> normal advance.
- pcsource=10, rpc=0x200; then pcsource=11, jpc=0x0FFF_FFF0 -> pc loads 0x200, then 0x0FFF_FFF0, each after its delay slot.
- Assert resetn=0 asynchronously mid-cycle while pend_valid=1 -> outputs take reset values immediately without waiting for a clock edge. After release -> fetch restarts at RESET_PC and the old target is never used.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings and constants for the MIPS fetch stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_J   = 2'b11
  } pcsrc_e;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pipe_npc_mux.sv
// Next-PC select: decode redirect target, overridden by a latched pending redirect.
module pipe_npc_mux
  import pipe_pkg::*;
(
  input  logic [31:0] pc4_i,
  input  logic [31:0] bpc_i,
  input  logic [31:0] rpc_i,
  input  logic [31:0] jpc_i,
  input  logic [1:0]  pcsource_i,
  input  logic        pend_valid_i,
  input  logic [31:0] pend_pc_i,
  output logic [31:0] tgt_o,
  output logic [31:0] npc_o
);

  always_comb begin
    tgt_o = pc4_i;
    case (pcsrc_e'(pcsource_i))
      PCSRC_SEQ: tgt_o = pc4_i;
      PCSRC_BR:  tgt_o = bpc_i;
      PCSRC_JR:  tgt_o = rpc_i;
      PCSRC_J:   tgt_o = jpc_i;
      default:   tgt_o = pc4_i;
    endcase
  end

  assign npc_o = pend_valid_i ? pend_pc_i : tgt_o;

endmodule

// File: rtl/pipe_fetch.sv
// Instruction fetch plus IF/ID register; delayed branches, multi-cycle imem handshake,
// and a pending-redirect latch so a branch target survives an imem wait.
module pipe_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC_P = RESET_PC,
  parameter logic [31:0] NOP_P      = NOP
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  input  logic [1:0]  pcsource,
  input  logic        wpcir,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] inst_q, inst_d;
  logic        dvalid_q, dvalid_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] pc4, tgt, npc;

  assign pc4 = pc_q + 32'd4;

  pipe_npc_mux u_npc_mux (
    .pc4_i        (pc4),
    .bpc_i        (bpc),
    .rpc_i        (rpc),
    .jpc_i        (jpc),
    .pcsource_i   (pcsource),
    .pend_valid_i (pend_valid_q),
    .pend_pc_i    (pend_pc_q),
    .tgt_o        (tgt),
    .npc_o        (npc)
  );

  always_comb begin
    pc_d         = pc_q;
    dpc4_d       = dpc4_q;
    inst_d       = inst_q;
    dvalid_d     = dvalid_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    if (wpcir) begin
      if (imem_rdy) begin
        pc_d         = npc;
        dpc4_d       = pc4;
        inst_d       = imem_rdata;
        dvalid_d     = 1'b1;
        pend_valid_d = 1'b0;
      end else begin
        inst_d   = NOP_P;
        dvalid_d = 1'b0;
        // Once a redirect is latched, decode holds a bubble so pcsource is stale.
        if (!pend_valid_q && (pcsrc_e'(pcsource) != PCSRC_SEQ)) begin
          pend_pc_d    = tgt;
          pend_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q         <= RESET_PC_P;
      dpc4_q       <= 32'h0;
      inst_q       <= NOP_P;
      dvalid_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      dpc4_q       <= dpc4_d;
      inst_q       <= inst_d;
      dvalid_q     <= dvalid_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign imem_req  = resetn;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign dpc4      = dpc4_q;
  assign inst      = inst_q;
  assign dvalid    = dvalid_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed table-driven bench for pipe_fetch, plus an async-reset-while-pending sequence.
module tb_pipe_fetch;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] bpc, jpc, rpc, imem_rdata;
  logic [1:0]  pcsource;
  logic        wpcir, imem_rdy;
  logic [31:0] imem_addr, pc, dpc4, inst;
  logic        imem_req, dvalid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pipe_fetch dut (
    .clock      (clock),
    .resetn     (resetn),
    .bpc        (bpc),
    .jpc        (jpc),
    .rpc        (rpc),
    .pcsource   (pcsource),
    .wpcir      (wpcir),
    .imem_rdy   (imem_rdy),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .pc         (pc),
    .dpc4       (dpc4),
    .inst       (inst),
    .dvalid     (dvalid)
  );

  typedef struct {
    logic        wpcir;
    logic        rdy;
    logic [1:0]  ps;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic [31:0] edpc4;
    logic [31:0] einst;
    logic        edv;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  function automatic vec_t mk(logic w, logic r, logic [1:0] ps, logic [31:0] b, logic [31:0] rr,
                              logic [31:0] j, logic [31:0] d, logic [31:0] epc,
                              logic [31:0] ed4, logic [31:0] ei, logic edv);
    vec_t v;
    v.wpcir = w; v.rdy = r; v.ps = ps; v.bpc = b; v.rpc = rr; v.jpc = j; v.rdata = d;
    v.epc = epc; v.edpc4 = ed4; v.einst = ei; v.edv = edv;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [31:0] epc, input logic [31:0] ed4,
                         input logic [31:0] ei, input logic edv, input logic ereq);
    chk("pc", idx, pc, epc);
    chk("imem_addr", idx, imem_addr, epc);
    chk("dpc4", idx, dpc4, ed4);
    chk("inst", idx, inst, ei);
    chk("dvalid", idx, {31'b0, dvalid}, {31'b0, edv});
    chk("imem_req", idx, {31'b0, imem_req}, {31'b0, ereq});
    $display("step %0d: pc=%h dpc4=%h inst=%h dvalid=%0d req=%0d", idx, pc, dpc4, inst, dvalid, imem_req);
  endtask

  task automatic drive(input logic w, input logic r, input logic [1:0] ps, input logic [31:0] b,
                       input logic [31:0] rr, input logic [31:0] j, input logic [31:0] d);
    wpcir = w; imem_rdy = r; pcsource = ps; bpc = b; rpc = rr; jpc = j; imem_rdata = d;
  endtask

  initial begin
    // Word at address a is modelled as 32'hA000_0000 | a.
    vt[0]  = mk(1, 1, 2'b00, 0, 0, 0, 32'hA000_0000, 32'h4,  32'h4,  32'hA000_0000, 1);
    vt[1]  = mk(1, 1, 2'b00, 0, 0, 0, 32'hA000_0004, 32'h8,  32'h8,  32'hA000_0004, 1);
    vt[2]  = mk(1, 1, 2'b00, 0, 0, 0, 32'hA000_0008, 32'hC,  32'hC,  32'hA000_0008, 1);
    vt[3]  = mk(1, 1, 2'b00, 0, 0, 0, 32'hA000_000C, 32'h10, 32'h10, 32'hA000_000C, 1);
    vt[4]  = mk(1, 1, 2'b01, 32'h40, 0, 0, 32'hA000_0010, 32'h40, 32'h14, 32'hA000_0010, 1);
    vt[5]  = mk(1, 1, 2'b00, 0, 0, 0, 32'hA000_0040, 32'h44, 32'h44, 32'hA000_0040, 1);
    vt[6]  = mk(1, 0, 2'b01, 32'h80, 0, 0, 32'hDEAD_BEEF, 32'h44, 32'h44, 32'h0, 0);
    vt[7]  = mk(1, 0, 2'b01, 32'h999, 0, 0, 32'hDEAD_BEEF, 32'h44, 32'h44, 32'h0, 0);
    vt[8]  = mk(1, 1, 2'b00, 0, 0, 0, 32'hA000_0044, 32'h80, 32'h48, 32'hA000_0044, 1);
    vt[9]  = mk(0, 1, 2'b01, 32'h300, 0, 0, 32'hA000_0080, 32'h80, 32'h48, 32'hA000_0044, 1);
    vt[10] = mk(0, 0, 2'b01, 32'h300, 0, 0, 32'hA000_0080, 32'h80, 32'h48, 32'hA000_0044, 1);
    vt[11] = mk(0, 1, 2'b00, 0, 0, 0, 32'hA000_0080, 32'h80, 32'h48, 32'hA000_0044, 1);
    vt[12] = mk(1, 1, 2'b00, 0, 0, 0, 32'hA000_0080, 32'h84, 32'h84, 32'hA000_0080, 1);
    vt[13] = mk(1, 1, 2'b10, 0, 32'h200, 0, 32'hA000_0084, 32'h200, 32'h88, 32'hA000_0084, 1);
    vt[14] = mk(1, 1, 2'b00, 0, 0, 0, 32'hA000_0200, 32'h204, 32'h204, 32'hA000_0200, 1);
    vt[15] = mk(1, 1, 2'b11, 0, 0, 32'h0FFF_FFF0, 32'hA000_0204, 32'h0FFF_FFF0, 32'h208, 32'hA000_0204, 1);
    vt[16] = mk(1, 1, 2'b00, 0, 0, 0, 32'hAFFF_FFF0, 32'h0FFF_FFF4, 32'h0FFF_FFF4, 32'hAFFF_FFF0, 1);
    vt[17] = mk(1, 0, 2'b00, 0, 0, 0, 32'h5555_5555, 32'h0FFF_FFF4, 32'h0FFF_FFF4, 32'h0, 0);
    vt[18] = mk(1, 1, 2'b00, 0, 0, 0, 32'hAFFF_FFF4, 32'h0FFF_FFF8, 32'h0FFF_FFF8, 32'hAFFF_FFF4, 1);
    vt[19] = mk(1, 1, 2'b11, 0, 0, 32'hFFFF_FFFC, 32'hAFFF_FFF8, 32'hFFFF_FFFC, 32'h0FFF_FFFC, 32'hAFFF_FFF8, 1);
    vt[20] = mk(1, 1, 2'b00, 0, 0, 0, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678, 1);
    vt[21] = mk(1, 1, 2'b00, 0, 0, 0, 32'hA000_0000, 32'h4, 32'h4, 32'hA000_0000, 1);

    resetn = 1'b0;
    drive(1, 1, 2'b00, 0, 0, 0, 0);
    #2;
    chk_all(-1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #10 resetn = 1'b1;
    #1;
    chk("imem_req_after_reset", -1, {31'b0, imem_req}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].wpcir, vt[i].rdy, vt[i].ps, vt[i].bpc, vt[i].rpc, vt[i].jpc, vt[i].rdata);
      @(posedge clock);
      #1;
      chk_all(i, vt[i].epc, vt[i].edpc4, vt[i].einst, vt[i].edv, 1'b1);
    end

    // Latch a pending redirect to 0x500, then reset asynchronously mid-cycle.
    drive(1, 0, 2'b01, 32'h500, 0, 0, 32'hDEAD_BEEF);
    @(posedge clock);
    #1;
    chk_all(100, 32'h4, 32'h4, 32'h0, 1'b0, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk_all(101, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 1, 2'b00, 0, 0, 0, 32'h1111_1111);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk_all(102, 32'h4, 32'h4, 32'h1111_1111, 1'b1, 1'b1);
    drive(1, 1, 2'b00, 0, 0, 0, 32'h2222_2222);
    @(posedge clock);
    #1;
    chk_all(103, 32'h8, 32'h8, 32'h2222_2222, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
